play_engine: RTL and testbench

PLAY_ENGINE -- requirements
Module: play_engine

---
 rtl/play_engine.sv | 170 +++++++++++++++++
 tb/tb_play_engine.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/play_engine.sv
// Sample playback engine: prefetches a word range from SDRAM into a small FIFO
// and streams it to an audio sink, with pause, loop and abort handling.
module play_engine #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              play_start,
    input  logic [ADDR_W-1:0] play_start_addr,
    input  logic [ADDR_W-1:0] play_end_addr,
    input  logic              play_loop,
    input  logic              play_pause,
    input  logic              play_stop,
    output logic              play_done,
    output logic              play_busy,
    output logic              play_read,
    output logic [ADDR_W-1:0] play_addr,
    input  logic [DATA_W-1:0] play_readdata,
    input  logic              play_sdram_finished,
    output logic              play_audio_valid,
    output logic [DATA_W-1:0] play_audio_data,
    input  logic              play_audio_ready,
    output logic [1:0]        play_state
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] start_r;
    logic [ADDR_W-1:0] end_r;
    logic              loop_r;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_done;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic in_fetch;
    logic rd_done;
    logic push;
    logic pop;
    logic flush;

    // Sink handshake: valid/ready sampled on the same rising edge; a sample
    // transfers when both are high, and valid only drops by the engine's own
    // state change (pause, abort, empty FIFO).
    assign play_busy        = (state != S_IDLE);
    assign play_state       = state;
    assign play_audio_valid = (state == S_RUN) && (count != '0);
    assign play_audio_data  = (count != '0) ? mem[rd_ptr] : '0;

    always_comb begin
        in_fetch = (state == S_RUN) || (state == S_PAUSE);
        rd_done  = play_read && play_sdram_finished;
        push     = in_fetch && rd_done && !play_stop;
        pop      = play_audio_valid && play_audio_ready;
        // A stop with no read in flight, or an abort whose read just landed,
        // empties the FIFO on the way back to idle.
        flush    = (in_fetch && play_stop && !(play_read && !play_sdram_finished))
                 || ((state == S_ABORT) && play_sdram_finished);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            start_r    <= '0;
            end_r      <= '0;
            loop_r     <= 1'b0;
            fetch_addr <= '0;
            fetch_done <= 1'b0;
            play_read  <= 1'b0;
            play_addr  <= '0;
            play_done  <= 1'b0;
        end else begin
            play_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (play_start && (play_end_addr >= play_start_addr)) begin
                        start_r    <= play_start_addr;
                        end_r      <= play_end_addr;
                        loop_r     <= play_loop;
                        fetch_addr <= play_start_addr;
                        fetch_done <= 1'b0;
                        play_read  <= 1'b1;
                        play_addr  <= play_start_addr;
                        state      <= S_RUN;
                    end
                end
                S_RUN, S_PAUSE: begin
                    if (play_stop) begin
                        if (play_read && !play_sdram_finished) begin
                            state <= S_ABORT;
                        end else begin
                            play_read <= 1'b0;
                            play_done <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else begin
                        if (rd_done) begin
                            play_read <= 1'b0;
                            if (fetch_addr == end_r) begin
                                if (loop_r) fetch_addr <= start_r;
                                else        fetch_done <= 1'b1;
                            end else begin
                                fetch_addr <= fetch_addr + ADDR_W'(1);
                            end
                        end else if (!play_read && !fetch_done && (count < DEPTH_C)) begin
                            play_read <= 1'b1;
                            play_addr <= fetch_addr;
                        end

                        if (state == S_RUN) begin
                            if (fetch_done && (count == '0)) begin
                                play_done <= 1'b1;
                                state     <= S_IDLE;
                            end else if (play_pause) begin
                                state <= S_PAUSE;
                            end
                        end else if (!play_pause) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_ABORT: begin
                    // The in-flight read must complete before the bus is released.
                    if (play_sdram_finished) begin
                        play_read <= 1'b0;
                        play_done <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= play_readdata;
    end

endmodule

// File: tb/tb_play_engine.sv
// Bench for play_engine: SDRAM responder, audio sink with a sample scoreboard,
// a table of playback ranges and hand-written pause/stop/loop/reset sequences.
module tb_play_engine;

    localparam int AW    = 23;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic          clk;
    logic          i_rst_n;
    logic          play_start;
    logic [AW-1:0] play_start_addr;
    logic [AW-1:0] play_end_addr;
    logic          play_loop;
    logic          play_pause;
    logic          play_stop;
    logic          play_done;
    logic          play_busy;
    logic          play_read;
    logic [AW-1:0] play_addr;
    logic [DW-1:0] play_readdata;
    logic          play_sdram_finished;
    logic          play_audio_valid;
    logic [DW-1:0] play_audio_data;
    logic          play_audio_ready;
    logic [1:0]    play_state;

    play_engine #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk               (clk),
        .i_rst_n             (i_rst_n),
        .play_start          (play_start),
        .play_start_addr     (play_start_addr),
        .play_end_addr       (play_end_addr),
        .play_loop           (play_loop),
        .play_pause          (play_pause),
        .play_stop           (play_stop),
        .play_done           (play_done),
        .play_busy           (play_busy),
        .play_read           (play_read),
        .play_addr           (play_addr),
        .play_readdata       (play_readdata),
        .play_sdram_finished (play_sdram_finished),
        .play_audio_valid    (play_audio_valid),
        .play_audio_data     (play_audio_data),
        .play_audio_ready    (play_audio_ready),
        .play_state          (play_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int rd_cnt   = 0;
    int smp_cnt  = 0;
    int done_cnt = 0;
    int rdy_mode = 0;
    bit sd_en    = 1'b1;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {9'h15A, a};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- SDRAM responder ----------------
    initial begin
        bit pending;
        int cnt;
        logic [AW-1:0] iss_addr;
        pending = 1'b0;
        cnt = 0;
        iss_addr = '0;
        play_sdram_finished = 1'b0;
        play_readdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!sd_en) begin
                pending = 1'b0;
            end else if (play_sdram_finished) begin
                play_sdram_finished = 1'b0;
            end else if (pending) begin
                if (!play_read) begin
                    pending = 1'b0;
                end else begin
                    check("read_addr_stable", play_addr, iss_addr);
                    cnt--;
                    if (cnt == 0) begin
                        play_sdram_finished = 1'b1;
                        play_readdata = data_of(play_addr);
                        pending = 1'b0;
                        rd_cnt++;
                        if (exp_addr_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL read_unexpected: actual=%0h required=none", play_addr);
                        end else begin
                            check("read_addr", play_addr, exp_addr_q.pop_front());
                        end
                    end
                end
            end else if (play_read) begin
                pending = 1'b1;
                cnt = LAT;
                iss_addr = play_addr;
            end
        end
    end

    // ---------------- audio sink driver ----------------
    initial begin
        play_audio_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       play_audio_ready = 1'b1;
                1:       play_audio_ready = 1'($urandom_range(0, 1));
                default: play_audio_ready = 1'b0;
            endcase
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (play_done) done_cnt++;
            if (play_audio_valid && play_audio_ready) begin
                smp_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sample_unexpected: actual=%0h required=none", play_audio_data);
                end else begin
                    check("sample_data", play_audio_data, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_counts();
        rd_cnt = 0;
        smp_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic start_play(input logic [AW-1:0] s, input logic [AW-1:0] e,
                              input bit lp, input bit accept);
        play_start_addr = s;
        play_end_addr   = e;
        play_loop       = lp;
        play_start      = 1'b1;
        if (accept && !lp) begin
            for (int i = 0; i <= int'(e - s); i++) begin
                exp_addr_q.push_back(s + AW'(i));
                exp_q.push_back(data_of(s + AW'(i)));
            end
        end
        tick();
        play_start = 1'b0;
        check("start_busy", play_busy, accept);
        check("start_read", play_read, accept);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (play_done) begin
                got = 1'b1;
                break;
            end
        end
        check(name, got, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read"},  play_read, 0);
        check({tag, "_done"},  play_done, 0);
        check({tag, "_busy"},  play_busy, 0);
        check({tag, "_valid"}, play_audio_valid, 0);
        check({tag, "_data"},  play_audio_data, 0);
        check({tag, "_addr"},  play_addr, 0);
        check({tag, "_state"}, play_state, 0);
    endtask

    task automatic drop_queues();
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        int            rdy;
        bit            accept;
        int            n_words;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{s: 23'h10,     e: 23'h13,     rdy: 0, accept: 1'b1, n_words: 4};
        vecs[1] = '{s: 23'h100,    e: 23'h100,    rdy: 0, accept: 1'b1, n_words: 1};
        vecs[2] = '{s: 23'h30,     e: 23'h3A,     rdy: 1, accept: 1'b1, n_words: 11};
        vecs[3] = '{s: 23'h50,     e: 23'h4F,     rdy: 0, accept: 1'b0, n_words: 0};
        vecs[4] = '{s: 23'h7FFFFE, e: 23'h7FFFFF, rdy: 1, accept: 1'b1, n_words: 2};

        i_rst_n = 1'b1;
        play_start = 1'b0;
        play_start_addr = '0;
        play_end_addr = '0;
        play_loop = 1'b0;
        play_pause = 1'b0;
        play_stop = 1'b0;
        #3 i_rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #2 i_rst_n = 1'b1;
        tick();

        // table-driven playback ranges
        for (int v = 0; v < 5; v++) begin
            clear_counts();
            rdy_mode = vecs[v].rdy;
            start_play(vecs[v].s, vecs[v].e, 1'b0, vecs[v].accept);
            if (vecs[v].accept) wait_done("vec_done", 300);
            else repeat (6) tick();
            tick();
            check("vec_reads",   rd_cnt,   vecs[v].n_words);
            check("vec_samples", smp_cnt,  vecs[v].n_words);
            check("vec_donecnt", done_cnt, vecs[v].accept);
            check("vec_busy",    play_busy, 0);
            check("vec_expq",    exp_q.size(), 0);
        end

        // backpressure: prefetch stops at FIFO depth, then drains
        clear_counts();
        rdy_mode = 2;
        start_play(23'h10, 23'h17, 1'b0, 1'b1);
        repeat (40) tick();
        check("bp_reads",     rd_cnt, DEPTH);
        check("bp_read_low",  play_read, 0);
        check("bp_samples",   smp_cnt, 0);
        check("bp_valid",     play_audio_valid, 1);
        rdy_mode = 0;
        wait_done("bp_done", 200);
        tick();
        check("bp_reads_all", rd_cnt, 8);
        check("bp_smp_all",   smp_cnt, 8);
        check("bp_donecnt",   done_cnt, 1);

        // loop mode: alternating addresses, no completion until stopped
        clear_counts();
        for (int i = 0; i < 24; i++) begin
            exp_addr_q.push_back(23'h20 + AW'(i % 2));
            exp_q.push_back(data_of(23'h20 + AW'(i % 2)));
        end
        start_play(23'h20, 23'h21, 1'b1, 1'b1);
        repeat (50) tick();
        check("loop_nodone", done_cnt, 0);
        check("loop_reads",  rd_cnt >= 8, 1);
        check("loop_busy",   play_busy, 1);
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        if (!play_done) wait_done("loop_stop_done", 20);
        tick();
        check("loop_stop_donecnt", done_cnt, 1);
        check("loop_stop_busy",    play_busy, 0);
        drop_queues();

        // stop while a read is in flight
        clear_counts();
        rdy_mode = 2;
        start_play(23'h40, 23'h47, 1'b0, 1'b1);
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        check("abort_state", play_state, 3);
        check("abort_read",  play_read, 1);
        check("abort_valid", play_audio_valid, 0);
        for (int i = 0; i < 10; i++) begin
            if (play_sdram_finished) break;
            tick();
        end
        check("abort_fin_seen", play_sdram_finished, 1);
        tick();
        check("abort_done",      play_done, 1);
        check("abort_read_low",  play_read, 0);
        check("abort_busy",      play_busy, 0);
        check("abort_fifo_empty", play_audio_data, 0);
        tick();
        check("abort_samples", smp_cnt, 0);
        check("abort_donecnt", done_cnt, 1);
        check("abort_reads",   rd_cnt, 1);
        drop_queues();
        rdy_mode = 0;

        // pause for 10 cycles mid-playback
        clear_counts();
        start_play(23'h60, 23'h67, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (play_audio_valid) break;
            tick();
        end
        check("pause_first_valid", play_audio_valid, 1);
        play_pause = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("pause_valid", play_audio_valid, 0);
            check("pause_state", play_state, 2);
            tick();
        end
        play_pause = 1'b0;
        wait_done("pause_done", 200);
        tick();
        check("pause_samples", smp_cnt, 8);
        check("pause_donecnt", done_cnt, 1);
        check("pause_expq",    exp_q.size(), 0);

        // pause and stop together behave as stop
        clear_counts();
        start_play(23'h70, 23'h77, 1'b0, 1'b1);
        repeat (6) tick();
        play_pause = 1'b1;
        play_stop  = 1'b1;
        tick();
        play_pause = 1'b0;
        play_stop  = 1'b0;
        check("pstop_not_pause", play_state != 2, 1);
        if (!play_done) wait_done("pstop_done", 20);
        tick();
        check("pstop_donecnt", done_cnt, 1);
        check("pstop_busy",    play_busy, 0);
        drop_queues();

        // asynchronous reset mid-fetch, late strobe, rejected start
        clear_counts();
        start_play(23'h80, 23'h87, 1'b0, 1'b1);
        #1 i_rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        @(posedge clk);
        #2 i_rst_n = 1'b1;
        drop_queues();
        sd_en = 1'b0;
        tick();
        play_readdata = 32'hDEAD_BEEF;
        play_sdram_finished = 1'b1;
        tick();
        play_sdram_finished = 1'b0;
        check("late_fin_busy",  play_busy, 0);
        check("late_fin_read",  play_read, 0);
        check("late_fin_valid", play_audio_valid, 0);
        check("late_fin_state", play_state, 0);
        sd_en = 1'b1;
        start_play(23'h90, 23'h8F, 1'b0, 1'b0);
        tick();
        check("reject_state", play_state, 0);
        check("reject_busy",  play_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
